// File: rtl/ysyx_23060124__axi_burst_rsp.sv
// AXI4 read-burst responder backed by a preloadable word array.
// Optional random inter-beat gaps: define YSYX_23060124_AXI_RSP_DELAY_EN.
module ysyx_23060124__axi_burst_rsp #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  input  logic [3:0]                     S_AXI_ARID,
  input  logic [7:0]                     S_AXI_ARLEN,
  input  logic [2:0]                     S_AXI_ARSIZE,
  input  logic [1:0]                     S_AXI_ARBURST,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [3:0]                     S_AXI_RID,
  output logic                           S_AXI_RLAST,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  logic [DATA_WIDTH-1:0]          ld_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + ((ADDR_WIDTH+1)'(DEPTH_WORDS) << 2);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_beat;
  logic [1:0]            r_burst, r_rresp;
  logic                  r_err, r_rvalid, r_rlast;
  logic [3:0]            r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_ar_hs, w_r_hs, w_adv, w_load, w_in_range;
  logic [ADDR_WIDTH-1:0] w_cur_addr, w_next_addr, w_off;
  logic [1:0]            w_cur_burst, w_beat_resp;
  logic [7:0]            w_cur_len, w_cur_beat;
  logic                  w_cur_err;
  logic [DATA_WIDTH-1:0] w_beat_data;

  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] mask;
    mask = (ADDR_WIDTH'(len) << 2) | ADDR_WIDTH'(2'd3);
    case (burst)
      2'b00:   f_next_addr = a;
      2'b01:   f_next_addr = a + ADDR_WIDTH'(3'd4);
      2'b10:   f_next_addr = (a & ~mask) | ((a + ADDR_WIDTH'(3'd4)) & mask);
      default: f_next_addr = a;
    endcase
  endfunction

  function automatic logic f_burst_err(input logic [1:0] burst, input logic [7:0] len,
                                       input logic [2:0] size);
    logic bad_wrap;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: bad_wrap = 1'b0;
      default:                 bad_wrap = 1'b1;
    endcase
    f_burst_err = (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && bad_wrap);
  endfunction

  assign w_ar_hs = S_AXI_ARVALID && (r_state == S_IDLE);
  assign w_r_hs  = r_rvalid && S_AXI_RREADY;
  assign w_adv   = w_ar_hs || (w_r_hs && !r_rlast);

`ifdef YSYX_23060124_AXI_RSP_DELAY_EN
  logic [3:0] r_lfsr;
  logic       r_wait;
  logic [1:0] r_gap;

  assign w_load = (w_adv && (r_lfsr[1:0] == 2'b00)) || (r_wait && (r_gap == 2'd1));

  // Free-running LFSR and the idle-gap countdown it seeds before each beat
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= 4'b1001;
      r_wait <= 1'b0;
      r_gap  <= 2'd0;
    end else begin
      r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      if (w_adv && (r_lfsr[1:0] != 2'b00)) begin
        r_wait <= 1'b1;
        r_gap  <= r_lfsr[1:0];
      end else if (r_wait) begin
        r_wait <= (r_gap != 2'd1);
        r_gap  <= r_gap - 2'd1;
      end
    end
  end
`else
  assign w_load = w_adv;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and address-channel ready
  always_comb begin
    w_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    case (r_state)
      S_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) w_state_nxt = S_BURST;
        else               w_state_nxt = S_IDLE;
      end
      S_BURST: begin
        if (w_r_hs && r_rlast) w_state_nxt = S_IDLE;
        else                   w_state_nxt = S_BURST;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // First beat is sourced straight from AR so it can appear the cycle after the handshake
  always_comb begin
    if (r_state == S_IDLE) begin
      w_cur_addr  = S_AXI_ARADDR;
      w_cur_burst = S_AXI_ARBURST;
      w_cur_len   = S_AXI_ARLEN;
      w_cur_err   = f_burst_err(S_AXI_ARBURST, S_AXI_ARLEN, S_AXI_ARSIZE);
      w_cur_beat  = 8'd0;
    end else begin
      w_cur_addr  = r_addr;
      w_cur_burst = r_burst;
      w_cur_len   = r_len;
      w_cur_err   = r_err;
      w_cur_beat  = r_beat;
    end
  end

  assign w_next_addr = f_next_addr(w_cur_addr, w_cur_burst, w_cur_len);
  assign w_off       = w_cur_addr - BASE_ADDR;
  assign w_in_range  = ({1'b0, w_cur_addr} >= LO_ADDR) && ({1'b0, w_cur_addr} < HI_ADDR);

  // Response and data for the beat being loaded; errors force zero data
  always_comb begin
    w_beat_data = '0;
    w_beat_resp = 2'b00;
    if (w_cur_err) begin
      w_beat_resp = 2'b10;
    end else if (!w_in_range) begin
      w_beat_resp = 2'b11;
    end else begin
      w_beat_data = r_mem[IDX_W'(w_off >> 2)];
    end
  end

  // Burst context and registered R channel
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr   <= '0;
      r_len    <= 8'd0;
      r_burst  <= 2'b00;
      r_err    <= 1'b0;
      r_beat   <= 8'd0;
      r_rid    <= 4'd0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_addr  <= S_AXI_ARADDR;
        r_len   <= S_AXI_ARLEN;
        r_burst <= S_AXI_ARBURST;
        r_err   <= f_burst_err(S_AXI_ARBURST, S_AXI_ARLEN, S_AXI_ARSIZE);
        r_rid   <= S_AXI_ARID;
        r_beat  <= 8'd0;
      end
      if (w_load) begin
        r_addr   <= w_next_addr;
        r_beat   <= w_cur_beat + 8'd1;
        r_rvalid <= 1'b1;
        r_rdata  <= w_beat_data;
        r_rresp  <= w_beat_resp;
        r_rlast  <= (w_cur_beat == w_cur_len);
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  // Preload port; array is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (ld_en) r_mem[ld_idx] <= ld_data;
  end

  assign S_AXI_RDATA  = r_rdata;
  assign S_AXI_RRESP  = r_rresp;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RID    = r_rid;
  assign S_AXI_RLAST  = r_rlast;

endmodule

// File: doc/ysyx_23060124__axi_burst_rsp.md
YSYX_23060124__AXI_BURST_RSP -- requirements
Module: ysyx_23060124__axi_burst_rsp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AR address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: R data width; only 32 supported.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024: backing array depth in 32-bit words, a power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h3000_0000: byte address of word 0.
REQ-005 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports S_AXI_ARADDR in 32, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_ARID in 4, S_AXI_ARLEN in 8, S_AXI_ARSIZE in 3, S_AXI_ARBURST in 2: the AXI4 read address channel.
REQ-008 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RID out 4, S_AXI_RLAST out 1: the AXI4 read data channel.
REQ-009 SHALL have ports ld_en in 1, ld_idx in log2(DEPTH_WORDS), ld_data in 32: preload write port, writing ld_data to word ld_idx when ld_en is high.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and BURST.
REQ-011 In IDLE, ARREADY SHALL be 1 and RVALID SHALL be 0; in BURST, ARREADY SHALL be 0.
REQ-012 On an AR handshake in cycle T, the block SHALL latch ARADDR, ARID, ARLEN, ARSIZE and ARBURST, enter BURST, and present the first beat with RVALID=1 in cycle T+1.
REQ-013 Beat count SHALL be ARLEN+1 (1..256); RLAST SHALL be 1 only on the final beat.
REQ-014 While RVALID=1 and RREADY=0, RDATA, RRESP, RID and RLAST SHALL hold stable.
REQ-015 On RVALID&&RREADY on a non-last beat, the next beat SHALL be presented the following cycle (back-to-back, no bubble).
REQ-016 On RVALID&&RREADY&&RLAST, the block SHALL return to IDLE; ARREADY SHALL be 1 the next cycle, with no overlap of address and data phases.
REQ-017 RID SHALL equal the latched ARID on every beat.
REQ-018 Beat address rules: FIXED (00) repeats the start address; INCR (01) adds 4 per beat with 32-bit wrap; WRAP (10) adds 4 within an aligned window of (ARLEN+1)*4 bytes and wraps to the window base.
REQ-019 WRAP with ARLEN not in {1,3,7,15}, burst type 11, or ARSIZE != 3'b010 SHALL make every beat of the burst RRESP=SLVERR (2'b10) with RDATA=0; beat count is still ARLEN+1.
REQ-020 A beat whose address is below BASE_ADDR or at/above BASE_ADDR+4*DEPTH_WORDS SHALL return RRESP=DECERR (2'b11) with RDATA=0; in-range beats SHALL return OKAY (00).
REQ-021 Array word index SHALL be (addr-BASE_ADDR)>>2; address bits [1:0] SHALL be ignored.
REQ-022 A beat's data SHALL be captured from the array in the cycle it becomes visible; a preload write to the same word in that cycle SHALL NOT affect it (old data is returned).

Reset
REQ-023 While reset is high: ARREADY=1, RVALID=0, RLAST=0, RRESP=0, RDATA=0, RID=0, FSM=IDLE, beat counter=0.
REQ-024 Reset asserted mid-burst SHALL abort the burst; remaining beats SHALL NOT be issued.
REQ-025 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-026 Macro YSYX_23060124_AXI_RSP_DELAY_EN: when defined, a 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001, advancing every cycle) SHALL insert LFSR[1:0] idle cycles (0-3, RVALID=0) before each beat, including the first.
REQ-027 When the macro is undefined, the LFSR logic SHALL be absent and timing SHALL be exactly that of REQ-012 and REQ-015.

Verification (macro undefined unless stated)
REQ-028 Preload words 0..7 with 32'h1000_0000+i; AR 32'h3000_0000, ARLEN=7, INCR, ARID=3, RREADY=1 -> 8 beats in cycles T+1..T+8 carrying 32'h1000_0000..07, RID=3, RLAST only on beat 8, ARREADY=1 at T+9.
REQ-029 Same burst with RREADY low on beat 3 for 4 cycles -> beat 3 data 32'h1000_0002 held stable, no beat skipped or duplicated.
REQ-030 WRAP, ARLEN=3, ARADDR 32'h3000_0008 -> data for words 2,3,0,1, all OKAY.
REQ-031 INCR, ARLEN=1, ARADDR BASE+4*DEPTH_WORDS-4 -> beat 1 OKAY with word 1023's data; beat 2 DECERR with RDATA 0. Separately, ARSIZE=3'b001 with ARLEN=2 -> 3 SLVERR beats.
REQ-032 Reset asserted on beat 2 of an 8-beat burst -> next cycle RVALID=0 and ARREADY=1; a new burst then completes normally. With YSYX_23060124_AXI_RSP_DELAY_EN defined, the REQ-028 data sequence is unchanged and gaps match the LFSR.
